// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder controller.
// Accepts two packed BCD operands and a carry-in, runs them through a single
// digit adder one digit per clock (least-significant first), and presents the
// sum, carry-out and an invalid-digit flag until the consumer takes them.
//
//  state  | meaning
//  -------+----------------------------------------------------------------
//  IDLE   | waiting for operands, in_ready high
//  RUN    | one digit per clock through bcd_fadd, counter tracks the digit
//  DONE   | result registers valid, held until out_ready

// Single-digit BCD full adder. Invalid input digits still give a
// deterministic (but meaningless) result; the controller flags them.
module bcd_fadd (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] temp;
    logic [3:0] adj;

    // Binary add, then +6 correction when the digit overflows decimal range.
    always_comb begin
        temp = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        adj  = temp[3:0] + 4'd6;
        sum  = temp[3:0];
        cout = 1'b0;
        if (temp > 5'd9) begin
            sum  = adj;
            cout = 1'b1;
        end
    end

endmodule

module bcd_serial_add_ctrl #(
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_a,
    input  logic [4*DIGITS-1:0]   in_b,
    input  logic                  in_cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_sum,
    output logic                  out_cout,
    output logic                  out_err,
    output logic                  busy
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    sa_q, sa_d;
    logic [W-1:0]    sb_q, sb_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            oerr_q, oerr_d;

    logic [3:0]      dig_sum;
    logic            dig_cout;
    logic            dig_bad;
    logic            run_step;
    logic            last_digit;
    logic [W-1:0]    full_sum;

    bcd_fadd u_fadd (
        .a    (sa_q[3:0]),
        .b    (sb_q[3:0]),
        .cin  (carry_q),
        .sum  (dig_sum),
        .cout (dig_cout)
    );

    assign dig_bad    = (sa_q[3:0] > 4'd9) || (sb_q[3:0] > 4'd9);
    assign run_step   = (state_q == S_RUN);
    assign last_digit = (cnt_q == CNT_LAST);

    // Partial result register: digits computed so far shift in from the top.
    // Only DIGITS-1 digits need storing; the last digit comes straight from
    // the adder on the final edge, when the whole sum is copied out.
    generate
        if (DIGITS == 1) begin : g_one
            assign full_sum = dig_sum;
        end else begin : g_multi
            localparam int PW = 4 * (DIGITS - 1);
            logic [PW-1:0] part_q, part_d;
            logic [PW-1:0] part_shift;

            if (DIGITS == 2) begin : g_two
                assign part_shift = dig_sum;
            end else begin : g_wide
                assign part_shift = {dig_sum, part_q[PW-1:4]};
            end

            assign full_sum = {dig_sum, part_q};

            // Shift a new digit in on every RUN edge.
            always_comb begin
                part_d = part_q;
                if (run_step) begin
                    part_d = part_shift;
                end
            end

            // Partial result storage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    part_q <= '0;
                end else begin
                    part_q <= part_d;
                end
            end
        end
    endgenerate

    // Next-state and datapath control for the digit sequencer.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        oerr_d  = oerr_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sa_d    = in_a;
                    sb_d    = in_b;
                    carry_d = in_cin;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sa_d    = sa_q >> 4;
                sb_d    = sb_q >> 4;
                carry_d = dig_cout;
                err_d   = err_q | dig_bad;
                if (last_digit) begin
                    // Output registers change only here, so they hold
                    // their value from one DONE to the next.
                    sum_d   = full_sum;
                    cout_d  = dig_cout;
                    oerr_d  = err_q | dig_bad;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            oerr_q  <= oerr_d;
        end
    end

    // Handshake outputs depend on state only.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_err   = oerr_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl: scoreboard of expected results pushed at
// each accepted transaction and popped when the result handshake completes.
module tb_bcd_serial_add_ctrl;

    localparam int D = 8;
    localparam int W = 4 * D;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        int           acc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_err;
    logic         busy;

    logic         in_valid1, in_ready1, cin1, out_valid1, out_ready1;
    logic [3:0]   a1, b1, sum1;
    logic         cout1, err1, busy1;

    exp_t         sb[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           last_rise = 0;
    int           b2b_rises = 0;
    bit           b2b_on  = 0;
    logic         prev_valid = 0;

    bcd_serial_add_ctrl #(.DIGITS(D)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_err   (out_err),
        .busy      (busy)
    );

    bcd_serial_add_ctrl #(.DIGITS(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_a      (a1),
        .in_b      (b1),
        .in_cin    (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_sum   (sum1),
        .out_cout  (cout1),
        .out_err   (err1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Independent decimal reference for valid BCD operands.
    function automatic int bcd_to_int(input logic [W-1:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W:0] dec_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int           s;
        logic [W-1:0] r;
        s = bcd_to_int(a) + bcd_to_int(b) + int'(c);
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(s % 10);
            s = s / 10;
        end
        return {(s != 0), r};
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Result monitor: latency, spacing and scoreboard compare.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !prev_valid) begin
                check("result_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) check("latency", 64'(cyc - sb[0].acc), 64'(D));
                if (b2b_on && b2b_rises > 0) check("b2b_spacing", 64'(cyc - last_rise), 64'(D + 2));
                if (b2b_on) b2b_rises++;
                last_rise = cyc;
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sum",  64'(out_sum),  64'(e.sum));
                check("cout", 64'(out_cout), 64'(e.cout));
                check("err",  64'(out_err),  64'(e.err));
            end
        end
        prev_valid = out_valid;
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] es, input logic ec, input logic ee,
                        input bit expect_out, input bit hold_valid);
        int budget = 0;
        while (!in_ready && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        @(posedge clk); #1;
        if (expect_out) sb.push_back('{sum: es, cout: ec, err: ee, acc: cyc});
        if (!hold_valid) in_valid = 1'b0;
        in_a   = ~a;
        in_b   = ~b;
        in_cin = ~cin;
    endtask

    task automatic send_rand(input bit hold_valid);
        logic [W-1:0] a, b;
        logic         c;
        logic [W:0]   r;
        a = rand_bcd();
        b = rand_bcd();
        c = 1'($urandom_range(0, 1));
        r = dec_add(a, b, c);
        send(a, b, c, r[W-1:0], r[W], 1'b0, 1'b1, hold_valid);
    endtask

    task automatic drain();
        int budget = 0;
        while (sb.size() != 0 && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_cin     = 1'b0;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        a1         = '0;
        b1         = '0;
        cin1       = 1'b0;
        out_ready1 = 1'b1;
        #12;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum",   64'(out_sum),   64'd0);
        check("rst_out_cout",  64'(out_cout),  64'd0);
        check("rst_out_err",   64'(out_err),   64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        send(32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        send(32'h99999999, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
        drain();
        send(32'h99999999, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
        drain();
        send(32'h0000A000, 32'h00000000, 1'b0, 32'h00010000, 1'b0, 1'b1, 1'b1, 1'b0);
        drain();
        send(32'h00000005, 32'h00000004, 1'b0, 32'h00000009, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();

        // Backpressure in DONE.
        out_ready = 1'b0;
        send(32'h00123456, 32'h00654321, 1'b1, 32'h00777778, 1'b0, 1'b0, 1'b1, 1'b0);
        begin
            int budget = 0;
            while (!out_valid && budget < 50) begin
                @(posedge clk); #1;
                budget++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",    64'(out_valid), 64'd1);
            check("bp_sum",      64'(out_sum),   64'h00777778);
            check("bp_in_ready", 64'(in_ready),  64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready",  64'(in_ready),  64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        drain();

        // Asynchronous reset mid-RUN at counter 3.
        send(32'h11111111, 32'h22222222, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #4 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready",  64'(in_ready),  64'd1);
        check("abort_busy",      64'(busy),      64'd0);
        #13 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("post_abort_out_valid", 64'(out_valid), 64'd0);
        check("post_abort_in_ready",  64'(in_ready),  64'd1);
        send(32'h00000050, 32'h00000050, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();

        // Back-to-back with in_valid and out_ready held high.
        b2b_on    = 1'b1;
        b2b_rises = 0;
        for (int i = 0; i < 3; i++) send_rand(i < 2);
        drain();
        check("b2b_count", 64'(b2b_rises), 64'd3);
        b2b_on = 1'b0;

        // Single-digit build: RUN lasts one cycle.
        a1        = 4'd9;
        b1        = 4'd9;
        cin1      = 1'b1;
        in_valid1 = 1'b1;
        check("d1_in_ready", 64'(in_ready1), 64'd1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        a1        = 4'd0;
        b1        = 4'd0;
        check("d1_busy_run", 64'(busy1), 64'd1);
        check("d1_not_done", 64'(out_valid1), 64'd0);
        @(posedge clk); #1;
        check("d1_valid", 64'(out_valid1), 64'd1);
        check("d1_sum",   64'(sum1),       64'd9);
        check("d1_cout",  64'(cout1),      64'd1);
        check("d1_err",   64'(err1),       64'd0);
        @(posedge clk); #1;
        check("d1_idle", 64'(in_ready1), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
